alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Pipelined issue/retire wrapper around the combinational 32-bit ALU built from one-bit slices. It accepts operations from decode over a valid/ready handshake and registers them in an issue stage that drives the ALU operands and function code. It then captures the ALU result, with zero and illegal-op flags, in a retire register for writeback. The block is elastic, sustains one operation per cycle, and keeps retired and illegal-op counters.

## Interface
- `WIDTH`, 32, operand/result width (matches ALU width)
- `TAG_W`, 4, width of the opaque destination tag carried alongside each op
- `CNT_W`, 16, width of the statistics counters
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decode presents an op
- `in_ready`  out  1  issue stage can accept this cycle
- `in_funct`  in  6  function code (AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010)
- `in_a`, `in_b`  in  WIDTH  operands
- `in_tag`  in  TAG_W  destination tag
- `alu_signal`  out  6  function code to ALU
- `alu_a`, `alu_b`  out  WIDTH  operands to ALU
- `alu_result`  in  WIDTH  combinational ALU result
- `out_valid`  out  1  retire register holds a result
- `out_ready`  in  1  writeback accepts
- `out_result`  out  WIDTH  registered result
- `out_zero`  out  1  `out_result == 0`
- `out_illegal`  out  1  op had an unsupported funct
- `out_tag`  out  TAG_W  tag of retired op
- `retired_cnt`  out  CNT_W  ops handed to writeback
- `illegal_cnt`  out  CNT_W  illegal ops handed to writeback

## Operation
- Two registered stages: S1 (issue) and S2 (retire). The ALU sits combinationally between them.
- S2 advances (`adv2`) when `s1_valid && (!out_valid || out_ready)`.
- `in_ready = !s1_valid || adv2`. This is combinational from `out_ready`. There is no skid buffer.
- Accept (`in_valid && in_ready`):
  - S1 loads funct, a, b, tag.
  - S1 sets `s1_illegal` when funct is not one of the five codes.
- `alu_signal`/`alu_a`/`alu_b` always reflect S1 register contents. They hold their last value while S1 is empty.
- On `adv2`:
  - `out_result` ← `alu_result`, or 0 if `s1_illegal`.
  - `out_zero` ← (loaded result == 0), so an illegal op retires with `out_zero`=1.
  - `out_illegal` and `out_tag` ← S1 values.
  - `out_valid` ← 1.
- S1 empties when it advances without a new accept in the same cycle.
- `out_valid` clears on `out_ready && !adv2`.
- S2 contents are stable while `out_valid && !out_ready`.
- Counters increment on each `out_valid && out_ready`:
  - `retired_cnt` increments on every such handshake.
  - `illegal_cnt` increments additionally when `out_illegal`.
  - Both wrap from all-ones to 0 silently.
- SLT results are taken from the ALU unmodified: bit 0 = less, upper bits 0.

## Timing
- Reset (async assert, sync release):
  - S1 valid=0 and all S1 fields 0, so `alu_signal`=0 and `alu_a`=`alu_b`=0.
  - `out_valid`=0; `out_result`, `out_zero`, `out_illegal`, `out_tag`=0.
  - Both counters = 0.
  - `in_ready`=1 after reset.
- Latency: op accepted at edge N appears with `out_valid`=1 after edge N+1 (2-cycle accept-to-output), when S2 is free.
- Throughput: one op per cycle while `out_ready`=1.
- Both stages full with `out_ready`=0: `in_ready`=0 and no state changes.
- Simultaneous accept + S1→S2 advance + writeback handshake in one cycle: all three occur; no bubble is inserted.
- Reset mid-operation discards every in-flight op. Counters return to 0.
- Upstream must hold `in_*` stable while `in_valid && !in_ready`. The block never drops or duplicates an op.

## Structure
- Package `alu_pkg`:
  - funct constants `FUNCT_AND`, `FUNCT_OR`, `FUNCT_ADD`, `FUNCT_SUB`, `FUNCT_SLT`
  - function `funct_legal`
  - default `WIDTH`
- One sub-module, `alu_stage_reg`: a generic valid/ready pipeline register. Instantiated for S2.
- S1 is inline, because of the illegal decode.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- ADD 5+7, `out_ready`=1 → after two edges `out_result`=12, `out_zero`=0, tag echoed, `retired_cnt`=1.
- SUB 9−9 then SLT 3<8, back-to-back → results 0 (`out_zero`=1) and 1 on consecutive cycles; `in_ready` stays 1.
- funct 6'b000111, A=1, B=1 → `out_result`=0, `out_zero`=1, `out_illegal`=1, `illegal_cnt`=1.
- Hold `out_ready`=0 and offer 3 ops → two accepted, `in_ready`=0 on the third. Release → results in order, none lost.
- Assert `rst_n`=0 with both stages full → `out_valid`=0 and counters 0 immediately; after release the first new op retires correctly.
- Preload a counter near wrap (force or 65536 handshakes) → `retired_cnt` wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/retire wrapper: default datapath
// width, the five supported function codes and a legality decode helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // True when the ALU implements the given function code.
  function automatic logic funct_legal(input logic [5:0] funct);
    logic legal;
    legal = 1'b0;
    case (funct)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_stage_reg.sv
// -----------------------------------------------------------------------------
// alu_stage_reg
// Generic one-entry valid/ready pipeline register (no skid buffer).
// Loads whenever it is empty or its content is leaving this cycle; the
// payload is held stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   in_data  [DW-1:0]     upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [DW-1:0]     registered payload
// -----------------------------------------------------------------------------
module alu_stage_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset too (not just the valid bit) so outputs
      // read as zero after reset; a pure datapath reg could skip this.
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Two-stage elastic wrapper around an external combinational ALU.
//   S1 (issue)  : registers funct/operands/tag from decode and drives the ALU.
//   S2 (retire) : captures the ALU result plus zero/illegal flags and tag.
// Sustains one op per cycle; keeps retired and illegal-op counters.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid/in_ready                   decode handshake
//   in_funct[5:0], in_a, in_b, in_tag   op from decode
//   alu_signal, alu_a, alu_b            S1 contents driven to the ALU
//   alu_result                          combinational ALU result
//   out_valid/out_ready                 writeback handshake
//   out_result, out_zero, out_illegal, out_tag   retired op
//   retired_cnt, illegal_cnt            wrapping handshake counters
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [5:0]       alu_signal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = WIDTH + TAG_W + 2;

  // ---------------------------------------------------------------- S1 issue
  logic             s1_valid;
  logic [5:0]       s1_funct;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_illegal;

  logic s2_ready;
  logic adv2;
  logic accept;

  assign adv2     = s1_valid && s2_ready;
  // Combinational from out_ready through s2_ready: a full S1 can still
  // accept when its op moves into S2 on the same edge.
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_funct   <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_funct   <= in_funct;
      s1_a       <= in_a;
      s1_b       <= in_b;
      s1_tag     <= in_tag;
      s1_illegal <= !funct_legal(in_funct);
    end else if (adv2) begin
      s1_valid   <= 1'b0;
    end
  end

  // Operands only change on accept, so the ALU inputs hold while S1 is empty.
  assign alu_signal = s1_funct;
  assign alu_a      = s1_a;
  assign alu_b      = s1_b;

  // --------------------------------------------------------------- S2 retire
  // Illegal ops retire with a forced zero result whatever the ALU produced.
  logic [WIDTH-1:0] s2_result_d;
  logic [PW-1:0]    s2_in;
  logic [PW-1:0]    s2_out;

  assign s2_result_d = s1_illegal ? '0 : alu_result;
  assign s2_in       = {s1_illegal, (s2_result_d == '0), s1_tag, s2_result_d};

  alu_stage_reg #(
    .DW (PW)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign {out_illegal, out_zero, out_tag, out_result} = s2_out;

  // ---------------------------------------------------------------- counters
  logic retire_hs;
  assign retire_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else if (retire_hs) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
      if (out_illegal) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench: vector table, hand-written multi-cycle sequences,
// randomized traffic against a queue-based reference model, counter wrap.
// The bench plays the external ALU; for unsupported codes it returns junk
// so a missing illegal-op override is visible.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic [5:0]       alu_signal;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .alu_signal  (alu_signal),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .out_tag     (out_tag),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ ALU + model
  function automatic logic is_legal(input logic [5:0] f);
    return (f == 6'b100100) || (f == 6'b100101) || (f == 6'b100000) ||
           (f == 6'b100010) || (f == 6'b101010);
  endfunction

  function automatic logic [31:0] ext_alu(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (f)
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b101010: r = {31'd0, ($signed(a) < $signed(b))};
      default:   r = a ^ 32'hA5A5_5A5A;
    endcase
    return r;
  endfunction

  always_comb alu_result = ext_alu(alu_signal, alu_a, alu_b);

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } op_t;

  function automatic logic [31:0] exp_result(input op_t op);
    return is_legal(op.f) ? ext_alu(op.f, op.a, op.b) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t op);
    in_valid = 1'b1;
    in_funct = op.f;
    in_a     = op.a;
    in_b     = op.b;
    in_tag   = op.tag;
  endtask

  function automatic op_t rand_op();
    op_t o;
    logic [5:0] fl [7];
    fl = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000111, 6'b111111};
    o.f   = fl[$urandom_range(6)];
    o.a   = ($urandom_range(1) != 0) ? 32'($urandom) : 32'($urandom_range(3));
    o.b   = ($urandom_range(1) != 0) ? 32'($urandom) : 32'($urandom_range(3));
    o.tag = 4'($urandom);
    return o;
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    op_t         op;
    logic [31:0] r;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  initial begin
    op_t p [3];
    op_t got [$];
    op_t mq [$];
    op_t cur, last, o;
    logic [31:0] got_r [$];
    bit   m_s1, m_s2, pending, hs, adv, acc, exp_ir;
    logic [15:0] m_ret, m_ill;
    int   k, hs_cnt;

    vecs[0]  = '{'{6'b100000, 32'd5, 32'd7, 4'h3},                    32'd12,        1'b0, 1'b0};
    vecs[1]  = '{'{6'b100010, 32'd9, 32'd9, 4'hA},                    32'd0,         1'b1, 1'b0};
    vecs[2]  = '{'{6'b101010, 32'd3, 32'd8, 4'h5},                    32'd1,         1'b0, 1'b0};
    vecs[3]  = '{'{6'b000111, 32'd1, 32'd1, 4'h7},                    32'd0,         1'b1, 1'b1};
    vecs[4]  = '{'{6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h1},    32'hF000_F000, 1'b0, 1'b0};
    vecs[5]  = '{'{6'b100101, 32'h0F0F_0000, 32'h0000_00F0, 4'h2},    32'h0F0F_00F0, 1'b0, 1'b0};
    vecs[6]  = '{'{6'b101010, 32'hFFFF_FFFF, 32'd1, 4'h9},            32'd1,         1'b0, 1'b0};
    vecs[7]  = '{'{6'b100000, 32'hFFFF_FFFF, 32'd1, 4'hC},            32'd0,         1'b1, 1'b0};
    vecs[8]  = '{'{6'b101010, 32'd8, 32'd3, 4'hD},                    32'd0,         1'b1, 1'b0};
    vecs[9]  = '{'{6'b100010, 32'd3, 32'd5, 4'hE},                    32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[10] = '{'{6'b111111, 32'h1234, 32'h5678, 4'hF},              32'd0,         1'b1, 1'b1};

    // ---------------------------------------------------------- reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_a = '0; in_b = '0; in_tag = '0;
    #12;
    check("rst_in_ready",    64'(in_ready),    64'(1));
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_out_result",  64'(out_result),  64'(0));
    check("rst_out_zero",    64'(out_zero),    64'(0));
    check("rst_out_illegal", 64'(out_illegal), 64'(0));
    check("rst_out_tag",     64'(out_tag),     64'(0));
    check("rst_alu_signal",  64'(alu_signal),  64'(0));
    check("rst_alu_a",       64'(alu_a),       64'(0));
    check("rst_alu_b",       64'(alu_b),       64'(0));
    check("rst_retired",     64'(retired_cnt), 64'(0));
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------------------------------------------------- table loop
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op);
      out_ready = 1'b1;
      #1;
      check("tbl_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      check("tbl_alu_signal", 64'(alu_signal), 64'(vecs[i].op.f));
      check("tbl_alu_ab",     {alu_a, alu_b},  {vecs[i].op.a, vecs[i].op.b});
      check("tbl_early_valid", 64'(out_valid), 64'(0));
      tick();
      check("tbl_out_valid",   64'(out_valid),   64'(1));
      check("tbl_out_result",  64'(out_result),  64'(vecs[i].r));
      check("tbl_out_zero",    64'(out_zero),    64'(vecs[i].z));
      check("tbl_out_illegal", 64'(out_illegal), 64'(vecs[i].ill));
      check("tbl_out_tag",     64'(out_tag),     64'(vecs[i].op.tag));
      if (i == 0) check("tbl_retired_pre", 64'(retired_cnt), 64'(0));
      tick();
      if (i == 0) check("tbl_retired_1", 64'(retired_cnt), 64'(1));
    end
    check("tbl_retired_total", 64'(retired_cnt), 64'(11));
    check("tbl_illegal_total", 64'(illegal_cnt), 64'(2));

    // ------------------------------------------- back-to-back SUB then SLT
    out_ready = 1'b1;
    drive('{6'b100010, 32'd9, 32'd9, 4'h1});
    #1 check("b2b_in_ready_a", 64'(in_ready), 64'(1));
    tick();
    drive('{6'b101010, 32'd3, 32'd8, 4'h2});
    #1 check("b2b_in_ready_b", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("b2b_a_valid",  64'(out_valid),  64'(1));
    check("b2b_a_result", 64'(out_result), 64'(0));
    check("b2b_a_zero",   64'(out_zero),   64'(1));
    check("b2b_a_tag",    64'(out_tag),    64'(1));
    tick();
    check("b2b_b_valid",  64'(out_valid),  64'(1));
    check("b2b_b_result", 64'(out_result), 64'(1));
    check("b2b_b_zero",   64'(out_zero),   64'(0));
    check("b2b_b_tag",    64'(out_tag),    64'(2));
    tick();
    check("b2b_drained",  64'(out_valid),  64'(0));

    // -------------------------------------------- backpressure, three ops
    p[0] = '{6'b100000, 32'd1, 32'd1, 4'h1};
    p[1] = '{6'b100000, 32'd2, 32'd2, 4'h2};
    p[2] = '{6'b100000, 32'd3, 32'd3, 4'h3};
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 3) drive(p[k]); else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    #1;
    check("bp_accepted",  64'(k),          64'(2));
    check("bp_in_ready",  64'(in_ready),   64'(0));
    check("bp_out_valid", 64'(out_valid),  64'(1));
    check("bp_result",    64'(out_result), 64'(2));
    check("bp_tag",       64'(out_tag),    64'(1));
    check("bp_alu_a",     64'(alu_a),      64'(2));
    tick();
    check("bp_hold_result", 64'(out_result), 64'(2));
    check("bp_hold_cnt",    64'(retired_cnt), 64'(13));
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (k < 3) drive(p[k]); else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        o.f = 6'b100000; o.a = 32'd0; o.b = 32'd0; o.tag = out_tag;
        got.push_back(o);
        got_r.push_back(out_result);
      end
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("bp_released", 64'(got.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        check("bp_order_result", 64'(got_r[i]),   64'(2 * (i + 1)));
        check("bp_order_tag",    64'(got[i].tag), 64'(i + 1));
      end
    end
    tick();
    check("bp_cnt_total", 64'(retired_cnt), 64'(16));

    // ----------------------------------------- reset with both stages full
    out_ready = 1'b0;
    drive('{6'b100000, 32'd10, 32'd20, 4'h4});
    tick();
    drive('{6'b100010, 32'd50, 32'd8, 4'h5});
    tick();
    in_valid = 1'b0;
    #1;
    check("rm_full_valid", 64'(out_valid), 64'(1));
    check("rm_full_ready", 64'(in_ready),  64'(0));
    #1 rst_n = 1'b0;
    #1;
    check("rm_out_valid", 64'(out_valid),   64'(0));
    check("rm_retired",   64'(retired_cnt), 64'(0));
    check("rm_illegal",   64'(illegal_cnt), 64'(0));
    check("rm_in_ready",  64'(in_ready),    64'(1));
    check("rm_alu_a",     64'(alu_a),       64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    drive('{6'b100000, 32'd100, 32'd23, 4'h6});
    tick();
    in_valid = 1'b0;
    tick();
    check("rm_new_valid",  64'(out_valid),  64'(1));
    check("rm_new_result", 64'(out_result), 64'(123));
    check("rm_new_tag",    64'(out_tag),    64'(6));
    tick();
    check("rm_new_cnt",    64'(retired_cnt), 64'(1));
    check("rm_no_dup",     64'(out_valid),   64'(0));

    // ------------------------------------------------ randomized vs model
    do_reset();
    mq.delete();
    m_s1 = 1'b0; m_s2 = 1'b0; pending = 1'b0;
    m_ret = '0; m_ill = '0;
    last = '{6'd0, 32'd0, 32'd0, 4'd0};
    cur  = last;
    for (int c = 0; c < 600; c++) begin
      if (!pending && c < 580 && $urandom_range(3) != 0) begin
        cur = rand_op();
        pending = 1'b1;
      end
      if (pending) drive(cur);
      else begin
        in_valid = 1'b0;
        in_funct = 6'($urandom);
        in_a     = 32'($urandom);
      end
      out_ready = (c >= 580) ? 1'b1 : ($urandom_range(2) != 0);
      #1;
      exp_ir = !m_s1 || !m_s2 || out_ready;
      check("rnd_in_ready",  64'(in_ready),  64'(exp_ir));
      check("rnd_out_valid", 64'(out_valid), 64'(m_s2));
      if (m_s2 && mq.size() > 0) begin
        check("rnd_result",  64'(out_result),  64'(exp_result(mq[0])));
        check("rnd_zero",    64'(out_zero),    64'(exp_result(mq[0]) == 32'd0));
        check("rnd_illegal", 64'(out_illegal), 64'(!is_legal(mq[0].f)));
        check("rnd_tag",     64'(out_tag),     64'(mq[0].tag));
      end
      check("rnd_retired_cnt", 64'(retired_cnt), 64'(m_ret));
      check("rnd_illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
      check("rnd_alu_ops", {alu_a, alu_b}, {last.a, last.b});
      check("rnd_alu_sig", 64'(alu_signal), 64'(last.f));
      hs  = m_s2 && out_ready;
      adv = m_s1 && (!m_s2 || out_ready);
      acc = pending && exp_ir;
      if (hs && mq.size() > 0) begin
        m_ret++;
        if (!is_legal(mq[0].f)) m_ill++;
        void'(mq.pop_front());
      end
      m_s2 = adv ? 1'b1 : (hs ? 1'b0 : m_s2);
      m_s1 = acc ? 1'b1 : (adv ? 1'b0 : m_s1);
      if (acc) begin
        mq.push_back(cur);
        last = cur;
        pending = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rnd_model_empty", 64'(mq.size()), 64'(0));
    check("rnd_final_valid", 64'(out_valid), 64'(0));

    // ------------------------------------------------------ counter wrap
    do_reset();
    drive('{6'b000000, 32'h55, 32'hAA, 4'h8});
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 70000 && hs_cnt < 65535; c++) begin
      if (out_valid && out_ready) hs_cnt++;
      tick();
    end
    check("wrap_handshakes", 64'(hs_cnt),      64'(65535));
    check("wrap_retired_ff", 64'(retired_cnt), 64'(16'hFFFF));
    check("wrap_illegal_ff", 64'(illegal_cnt), 64'(16'hFFFF));
    check("wrap_valid",      64'(out_valid),   64'(1));
    tick();
    check("wrap_retired_0",  64'(retired_cnt), 64'(0));
    check("wrap_illegal_0",  64'(illegal_cnt), 64'(0));
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
